// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel registered word mux, direct select (mode=0) or round-robin (mode=1).
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained with out_ready high.
// Backpressure: all in_ready drop while an unaccepted word sits in the output register.
// Optional per-channel saturating transfer counters are compiled in with RR_ARB_MUX_STATS_EN.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
`ifdef RR_ARB_MUX_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [NCH*16-1:0]    xfer_cnt
`endif
);

    logic [SELW-1:0]  last;
    logic             load;
    logic [NCH-1:0]   sel_hit;
    logic [NCH-1:0]   g_rr;
    logic [NCH-1:0]   xfer_vec;
    logic             xfer;
    logic [SELW-1:0]  xfer_idx;
    logic [WIDTH-1:0] xfer_dat;

    assign load = !out_valid || out_ready;

    // Out-of-range sel_in matches no channel, so nothing is ever readied.
    always_comb begin : direct_sel
        sel_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(sel_in) == i) begin
                sel_hit[i] = 1'b1;
            end
        end
    end

    always_comb begin : rr_grant
        logic found;
        int   idx;
        g_rr  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last) + k) % NCH;
            if (!found && in_valid[idx]) begin
                g_rr[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Gated by rst_n so no handshake can complete while reset is asserted.
    assign in_ready = (rst_n && load) ? (mode ? g_rr : sel_hit) : '0;
    assign xfer_vec = in_valid & in_ready;
    assign xfer     = |xfer_vec;

    always_comb begin : encode
        xfer_idx = '0;
        xfer_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (xfer_vec[i]) begin
                xfer_idx = SELW'(i);
                xfer_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SELW'(NCH - 1);
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= xfer_dat;
                out_sel  <= xfer_idx;
                if (mode) begin
                    last <= xfer_idx;
                end
            end
        end
    end

`ifdef RR_ARB_MUX_STATS_EN
    for (genvar c = 0; c < NCH; c++) begin : g_cnt
        logic [15:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (stat_clr) begin
                cnt <= '0;
            end else if (xfer_vec[c] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign xfer_cnt[c*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic against a transaction-level model.
// Stats checks are compiled only when RR_ARB_MUX_STATS_EN is defined.
module tb_rr_arb_mux;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           mode, out_ready, out_valid;
    logic [1:0]     sel_in, out_sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [W-1:0]   out_data;

    // Second instance with NCH=5 so sel_in can point past the last channel.
    logic           mode1, out_ready1, out_valid1;
    logic [2:0]     sel_in1, out_sel1;
    logic [39:0]    in_data1;
    logic [4:0]     in_valid1, in_ready1;
    logic [7:0]     out_data1;

`ifdef RR_ARB_MUX_STATS_EN
    logic           stat_clr, stat_clr1;
    logic [N*16-1:0] xfer_cnt;
    logic [79:0]    xfer_cnt1;
`endif

    rr_arb_mux #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_in(sel_in),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
`ifdef RR_ARB_MUX_STATS_EN
        , .stat_clr(stat_clr), .xfer_cnt(xfer_cnt)
`endif
    );

    rr_arb_mux #(.WIDTH(8), .NCH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode1), .sel_in(sel_in1),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sel(out_sel1)
`ifdef RR_ARB_MUX_STATS_EN
        , .stat_clr(stat_clr1), .xfer_cnt(xfer_cnt1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model of the output slot and arbitration pointer.
    int         m_last;
    bit         m_vld;
    logic [W-1:0] m_dat;
    int         m_sel;
    int         m_cnt[N];

    task automatic model_reset();
        m_last = N - 1;
        m_vld  = 0;
        m_dat  = '0;
        m_sel  = 0;
        for (int c = 0; c < N; c++) m_cnt[c] = 0;
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (!rst_n || (m_vld && !out_ready)) return r;
        if (!mode) begin
            r[sel_in] = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (in_valid[c]) begin
                    r[c] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Advance model by one clock using the inputs currently applied, then step the DUT.
    task automatic cycle();
        logic [N-1:0] t;
        bit ld;
        t  = exp_ready() & in_valid;
        ld = !m_vld || out_ready;
`ifdef RR_ARB_MUX_STATS_EN
        if (stat_clr) for (int c = 0; c < N; c++) m_cnt[c] = 0;
`endif
        if (t != '0) begin
            for (int c = 0; c < N; c++) begin
                if (t[c]) begin
                    m_vld = 1;
                    m_dat = in_data[c*W +: W];
                    m_sel = c;
                    if (mode) m_last = c;
`ifdef RR_ARB_MUX_STATS_EN
                    if (!stat_clr && m_cnt[c] < 65535) m_cnt[c]++;
`else
                    if (m_cnt[c] < 65535) m_cnt[c]++;
`endif
                end
            end
        end else if (ld) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; sel_in = 2'd0; in_valid = '1; out_ready = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++;
        if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_direct();
        mode = 1'b0; sel_in = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {$urandom, 32'hDEADBEEF, $urandom, $urandom};
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL direct_ready: got %b want 0100", in_ready); end
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== 2'd2) begin
            n_fail++; $display("FAIL direct_out: got v=%b d=%h s=%0d want v=1 d=deadbeef s=2", out_valid, out_data, out_sel);
        end
        in_valid = 4'b1011;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL direct_ready_novalid: got %b want 0100", in_ready); end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF || out_sel !== 2'd2) begin
            n_fail++; $display("FAIL direct_idle_hold: got v=%b d=%h s=%0d want v=0 d=deadbeef s=2", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_rr_all();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_checks++;
            if (in_ready !== 4'(1 << seq[k])) begin n_fail++; $display("FAIL rr_all_ready[%0d]: got %b want ch%0d", k, in_ready, seq[k]); end
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(seq[k]) || out_data !== m_dat) begin
                n_fail++; $display("FAIL rr_all_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", k, out_valid, out_sel, out_data, seq[k], m_dat);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int seq[4] = '{3, 1, 3, 1};
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_checks++;
            if (in_ready !== 4'(1 << seq[k])) begin n_fail++; $display("FAIL rr_sparse_ready[%0d]: got %b want ch%0d", k, in_ready, seq[k]); end
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(seq[k]) || out_data !== m_dat) begin
                n_fail++; $display("FAIL rr_sparse_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", k, out_valid, out_sel, out_data, seq[k], m_dat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_dat;
        logic [1:0]   held_sel;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        held_dat = out_data;
        held_sel = out_sel;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'(m_sel)) begin n_fail++; $display("FAIL bp_load: got v=%b s=%0d want v=1 s=%0d", out_valid, out_sel, m_sel); end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready); end
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_dat || out_sel !== held_sel) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want v=1 d=%h s=%0d", k, out_valid, out_data, out_sel, held_dat, held_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'(1 << ((held_sel + 1) % 4))) begin n_fail++; $display("FAIL bp_release_ready: got %b want ch%0d", in_ready, (held_sel + 1) % 4); end
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'((held_sel + 1) % 4) || out_data !== m_dat) begin
            n_fail++; $display("FAIL bp_release_out: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", out_valid, out_sel, out_data, (held_sel + 1) % 4, m_dat);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            mode      = 1'($urandom % 2);
            sel_in    = 2'($urandom % 4);
            in_valid  = 4'($urandom % 16);
            out_ready = ($urandom % 4) != 0;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_checks++;
            if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", k, in_ready, exp_ready()); end
            cycle();
            n_checks++;
            if (out_valid !== m_vld || out_data !== m_dat || out_sel !== 2'(m_sel)) begin
                n_fail++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", k, out_valid, out_data, out_sel, m_vld, m_dat, m_sel);
            end
        end
`ifdef RR_ARB_MUX_STATS_EN
        for (int c = 0; c < N; c++) begin
            n_checks++;
            if (xfer_cnt[c*16 +: 16] !== 16'(m_cnt[c])) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, xfer_cnt[c*16 +: 16], m_cnt[c]); end
        end
`endif
    endtask

    task automatic test_bad_sel();
        in_valid = '0; out_ready = 1'b1; mode1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sel_in1    = 3'(5 + $urandom % 3);
            in_valid1  = 5'(1 + $urandom % 31);
            out_ready1 = 1'($urandom % 2);
            in_data1   = {8'($urandom), $urandom};
            #1;
            n_checks++;
            if (in_ready1 !== 5'b00000) begin n_fail++; $display("FAIL badsel_ready[%0d]: got %b want 00000 sel=%0d", k, in_ready1, sel_in1); end
            cycle();
            n_checks++;
            if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL badsel_valid[%0d]: got %b want 0", k, out_valid1); end
        end
        in_valid1 = '0;
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got v=%b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_async: got v=%b d=%h s=%0d r=%b want all 0", out_valid, out_data, out_sel, in_ready);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1; in_valid = '0;
        #1;
    endtask

`ifdef RR_ARB_MUX_STATS_EN
    task automatic test_stats();
        mode = 1'b0; sel_in = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; stat_clr = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        n_checks++;
        if (xfer_cnt[15:0] !== 16'hFFFF || m_cnt[0] != 65535) begin n_fail++; $display("FAIL stats_sat: got %h want ffff", xfer_cnt[15:0]); end
        for (int c = 1; c < N; c++) begin
            n_checks++;
            if (xfer_cnt[c*16 +: 16] !== 16'(m_cnt[c])) begin n_fail++; $display("FAIL stats_other[%0d]: got %0d want %0d", c, xfer_cnt[c*16 +: 16], m_cnt[c]); end
        end
        stat_clr = 1'b1;
        cycle();
        n_checks++;
        if (xfer_cnt !== '0) begin n_fail++; $display("FAIL stats_clr: got %h want 0", xfer_cnt); end
        stat_clr = 1'b0;
        cycle();
        n_checks++;
        if (xfer_cnt[15:0] !== 16'd1 || m_cnt[0] != 1) begin n_fail++; $display("FAIL stats_after_clr: got %0d want 1", xfer_cnt[15:0]); end
    endtask
`endif

    initial begin
        mode1 = 1'b0; sel_in1 = 3'd0; in_valid1 = '0; in_data1 = '0; out_ready1 = 1'b1;
`ifdef RR_ARB_MUX_STATS_EN
        stat_clr = 1'b0; stat_clr1 = 1'b0;
`endif
        test_reset();
        test_direct();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_random();
        test_bad_sel();
        test_reset_mid();
`ifdef RR_ARB_MUX_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
